// File: rtl/dtb_pkg.sv
// Shared constants, state encoding and lane-count helper for the trace packer.
package dtb_pkg;

  localparam int unsigned TRB_WIDTH      = 64;
  localparam int unsigned TRB_MAX_TRACES = 8;
  localparam int unsigned NTRACE_W       = $clog2(TRB_MAX_TRACES);
  localparam int unsigned PTR_W          = $clog2(TRB_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FROZEN,
    EMPTY,
    WAIT,
    SHIFT
  } packer_state_t;

  // Active lane count: 2**ntrace, saturated at the physical lane count.
  function automatic logic [NTRACE_W:0] lanes_from_ntrace(input logic [NTRACE_W-1:0] ntrace);
    if (ntrace >= NTRACE_W'(NTRACE_W)) begin
      return (NTRACE_W+1)'(TRB_MAX_TRACES);
    end
    return (NTRACE_W+1)'(1) << ntrace;
  endfunction

endpackage

// File: rtl/trace_lane_mux.sv
// Combinational insert/extract of a lanes-wide slice at bit offset ptr_i.
module trace_lane_mux
  import dtb_pkg::*;
(
  input  logic [TRB_WIDTH-1:0]      word_i,
  input  logic [PTR_W-1:0]          ptr_i,
  input  logic [NTRACE_W-1:0]       ntrace_i,
  input  logic [TRB_MAX_TRACES-1:0] slice_i,
  output logic [TRB_WIDTH-1:0]      word_o,
  output logic [TRB_MAX_TRACES-1:0] slice_o
);

  logic [NTRACE_W:0] lanes;

  always_comb begin
    lanes   = lanes_from_ntrace(ntrace_i);
    word_o  = word_i;
    slice_o = '0;
    for (int unsigned k = 0; k < TRB_MAX_TRACES; k++) begin
      if (k < 32'(lanes)) begin
        word_o[ptr_i + PTR_W'(k)] = slice_i[k];
        slice_o[k]                = word_i[ptr_i + PTR_W'(k)];
      end
    end
  end

endmodule

// File: rtl/trace_packer.sv
// Trace capture packer / stream playback serialiser in front of the trace logger.
// Define TRACE_PACKER_STATS_EN to add the saturating DROP_CNT_O counter.
module trace_packer
  import dtb_pkg::*;
(
  input  logic                      CLK_I,
  input  logic                      RST_NI,
  input  logic                      MODE_I,
  input  logic [NTRACE_W-1:0]       NTRACE_I,
  input  logic [TRB_MAX_TRACES-1:0] TRACE_I,
  input  logic                      TRACE_VALID_I,
  input  logic                      TRG_I,
  input  logic                      TRG_DELAYED_I,
  input  logic                      STORE_PERM_I,
  output logic [TRB_WIDTH-1:0]      DATA_O,
  output logic                      STORE_O,
  output logic [PTR_W-1:0]          EVENT_POS_O,
  output logic                      TRG_EVENT_O,
  output logic                      OVERFLOW_O,
  output logic                      LOAD_REQUEST_O,
  input  logic                      LOAD_GRANT_I,
  input  logic [TRB_WIDTH-1:0]      DATA_I,
  output logic [TRB_MAX_TRACES-1:0] STREAM_O,
  output logic                      STREAM_VALID_O
`ifdef TRACE_PACKER_STATS_EN
  ,
  output logic [15:0]               DROP_CNT_O
`endif
);

  packer_state_t          state_q, state_d;
  logic                   mode_q;
  logic [NTRACE_W-1:0]    ntrace_q;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [TRB_WIDTH-1:0]   word_q, word_d;
  logic [TRB_WIDTH-1:0]   data_q, data_d;
  logic                   store_q, store_d;
  logic [PTR_W-1:0]       evpos_q, evpos_d;
  logic                   trg_ev_q, trg_ev_d;
  logic                   ovf_q, ovf_d;
  logic                   pend_q, pend_d;
  logic                   drop;
  logic                   trg_hit;
  logic                   cfg_chg;
  logic                   last;
  logic [NTRACE_W:0]      lanes;
  logic [PTR_W:0]         ptr_sum;
  logic [TRB_WIDTH-1:0]   word_ins;
  logic [TRB_MAX_TRACES-1:0] slice_ext;

  assign lanes   = lanes_from_ntrace(ntrace_q);
  assign ptr_sum = {1'b0, ptr_q} + (PTR_W+1)'(lanes);
  assign last    = (ptr_sum == (PTR_W+1)'(TRB_WIDTH));
  assign cfg_chg = (MODE_I != mode_q) || (NTRACE_I != ntrace_q);

  // word_q is the capture shadow in trace mode and the playback buffer in stream mode.
  trace_lane_mux u_mux (
    .word_i   (word_q),
    .ptr_i    (ptr_q),
    .ntrace_i (ntrace_q),
    .slice_i  (TRACE_I),
    .word_o   (word_ins),
    .slice_o  (slice_ext)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    word_d         = word_q;
    data_d         = data_q;
    store_d        = 1'b0;
    evpos_d        = evpos_q;
    trg_ev_d       = trg_ev_q;
    pend_d         = pend_q;
    drop           = 1'b0;
    trg_hit        = 1'b0;
    LOAD_REQUEST_O = 1'b0;
    STREAM_O       = '0;
    STREAM_VALID_O = 1'b0;

    if (cfg_chg) begin
      state_d = MODE_I ? EMPTY : IDLE;
      ptr_d   = '0;
      word_d  = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          trg_hit = (TRG_I | pend_q) & ~trg_ev_q;
          pend_d  = trg_hit & ~TRACE_VALID_I;
          if (TRACE_VALID_I) begin
            state_d = FILL;
            if (trg_hit) begin
              trg_ev_d = 1'b1;
              evpos_d  = ptr_q;
            end
            if (last) begin
              ptr_d  = '0;
              word_d = '0;
              if (STORE_PERM_I) begin
                data_d  = word_ins;
                store_d = 1'b1;
              end else begin
                drop = 1'b1;
              end
            end else begin
              ptr_d  = ptr_sum[PTR_W-1:0];
              word_d = word_ins;
            end
          end
          // Freezing waits one cycle after a store so the flush strobe never abuts it.
          if (state_q == FILL && TRG_DELAYED_I && !store_q) begin
            state_d = FROZEN;
            if (ptr_d != '0) begin
              data_d  = word_d;
              store_d = 1'b1;
            end
            ptr_d  = '0;
            word_d = '0;
          end
        end
        FROZEN: ;
        EMPTY: begin
          LOAD_REQUEST_O = 1'b1;
          state_d        = WAIT;
        end
        WAIT: begin
          LOAD_REQUEST_O = 1'b1;
          if (LOAD_GRANT_I) begin
            word_d  = DATA_I;
            ptr_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          STREAM_O       = slice_ext;
          STREAM_VALID_O = 1'b1;
          if (last) begin
            LOAD_REQUEST_O = 1'b1;
            ptr_d          = '0;
            if (LOAD_GRANT_I) begin
              word_d = DATA_I;
            end else begin
              state_d = WAIT;
            end
          end else begin
            ptr_d = ptr_sum[PTR_W-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      ntrace_q <= '0;
      ptr_q    <= '0;
      word_q   <= '0;
      data_q   <= '0;
      store_q  <= 1'b0;
      evpos_q  <= '0;
      trg_ev_q <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= MODE_I;
      ntrace_q <= NTRACE_I;
      ptr_q    <= ptr_d;
      word_q   <= word_d;
      data_q   <= data_d;
      store_q  <= store_d;
      evpos_q  <= evpos_d;
      trg_ev_q <= trg_ev_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
    end
  end

  assign DATA_O      = data_q;
  assign STORE_O     = store_q;
  assign EVENT_POS_O = evpos_q;
  assign TRG_EVENT_O = trg_ev_q;
  assign OVERFLOW_O  = ovf_q;

`ifdef TRACE_PACKER_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      drop_cnt_q <= '0;
    end else if (drop && drop_cnt_q != '1) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign DROP_CNT_O = drop_cnt_q;
`else
  // Drop events only feed the sticky OVERFLOW_O flag.
`endif

endmodule

// File: tb/tb_trace_packer.sv
// Self-checking bench for trace_packer against a word-level behavioural model.
module tb_trace_packer;

  logic        CLK_I = 1'b0;
  logic        RST_NI;
  logic        MODE_I;
  logic [2:0]  NTRACE_I;
  logic [7:0]  TRACE_I;
  logic        TRACE_VALID_I;
  logic        TRG_I;
  logic        TRG_DELAYED_I;
  logic        STORE_PERM_I;
  logic [63:0] DATA_O;
  logic        STORE_O;
  logic [5:0]  EVENT_POS_O;
  logic        TRG_EVENT_O;
  logic        OVERFLOW_O;
  logic        LOAD_REQUEST_O;
  logic        LOAD_GRANT_I;
  logic [63:0] DATA_I;
  logic [7:0]  STREAM_O;
  logic        STREAM_VALID_O;
`ifdef TRACE_PACKER_STATS_EN
  logic [15:0] DROP_CNT_O;
`endif

  int checks   = 0;
  int failures = 0;

  trace_packer dut (
    .CLK_I          (CLK_I),
    .RST_NI         (RST_NI),
    .MODE_I         (MODE_I),
    .NTRACE_I       (NTRACE_I),
    .TRACE_I        (TRACE_I),
    .TRACE_VALID_I  (TRACE_VALID_I),
    .TRG_I          (TRG_I),
    .TRG_DELAYED_I  (TRG_DELAYED_I),
    .STORE_PERM_I   (STORE_PERM_I),
    .DATA_O         (DATA_O),
    .STORE_O        (STORE_O),
    .EVENT_POS_O    (EVENT_POS_O),
    .TRG_EVENT_O    (TRG_EVENT_O),
    .OVERFLOW_O     (OVERFLOW_O),
    .LOAD_REQUEST_O (LOAD_REQUEST_O),
    .LOAD_GRANT_I   (LOAD_GRANT_I),
    .DATA_I         (DATA_I),
    .STREAM_O       (STREAM_O),
    .STREAM_VALID_O (STREAM_VALID_O)
`ifdef TRACE_PACKER_STATS_EN
    ,
    .DROP_CNT_O     (DROP_CNT_O)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic clear_inputs();
    TRACE_I       = '0;
    TRACE_VALID_I = 1'b0;
    TRG_I         = 1'b0;
    TRG_DELAYED_I = 1'b0;
    STORE_PERM_I  = 1'b1;
    LOAD_GRANT_I  = 1'b0;
    DATA_I        = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    MODE_I   = 1'b0;
    NTRACE_I = '0;
    RST_NI   = 1'b0;
    #2;
    check("rst_data",   DATA_O, 64'h0);
    check("rst_store",  STORE_O, 1'b0);
    check("rst_evpos",  EVENT_POS_O, 6'd0);
    check("rst_trgev",  TRG_EVENT_O, 1'b0);
    check("rst_ovf",    OVERFLOW_O, 1'b0);
    check("rst_req",    LOAD_REQUEST_O, 1'b0);
    check("rst_stream", STREAM_O, 8'h0);
    check("rst_svalid", STREAM_VALID_O, 1'b0);
`ifdef TRACE_PACKER_STATS_EN
    check("rst_dropcnt", DROP_CNT_O, 16'h0);
`endif
    step();
    RST_NI = 1'b1;
  endtask

  task automatic set_cfg(input logic mode, input logic [2:0] nt);
    MODE_I        = mode;
    NTRACE_I      = nt;
    TRACE_VALID_I = 1'b0;
    step();
    step();
  endtask

  task automatic sample(input logic [7:0] t, input logic v, input logic perm);
    TRACE_I       = t;
    TRACE_VALID_I = v;
    STORE_PERM_I  = perm;
    step();
  endtask

  function automatic int lanes_of(input int nt);
    return ((1 << nt) > 8) ? 8 : (1 << nt);
  endfunction

  // Word-level reference: samples are ORed in at lanes*index, a full word is stored or dropped.
  task automatic random_capture(input int nt, input int cycles);
    int          lanes;
    int          m_ptr;
    int          m_drops;
    logic [63:0] m_word;
    logic [63:0] mask;
    logic [63:0] exp_data;
    logic        m_ovf;
    logic        exp_store;
    logic        v;
    logic        perm;
    logic [7:0]  t;
    lanes   = lanes_of(nt);
    mask    = (64'd1 << lanes) - 64'd1;
    m_ptr   = 0;
    m_word  = '0;
    m_ovf   = 1'b0;
    m_drops = 0;
    exp_data = '0;
    do_reset();
    set_cfg(1'b0, 3'(nt));
    for (int c = 0; c < cycles; c++) begin
      v         = ($urandom_range(0, 9) < 7);
      perm      = ($urandom_range(0, 4) != 0);
      t         = 8'($urandom);
      exp_store = 1'b0;
      if (v) begin
        m_word = m_word | ((64'(t) & mask) << m_ptr);
        m_ptr  = m_ptr + lanes;
        if (m_ptr == 64) begin
          if (perm) begin
            exp_store = 1'b1;
            exp_data  = m_word;
          end else begin
            m_ovf   = 1'b1;
            m_drops = m_drops + 1;
          end
          m_ptr  = 0;
          m_word = '0;
        end
      end
      sample(t, v, perm);
      check("rnd_store", STORE_O, exp_store);
      if (exp_store) check("rnd_data", DATA_O, exp_data);
      check("rnd_ovf", OVERFLOW_O, m_ovf);
    end
`ifdef TRACE_PACKER_STATS_EN
    check("rnd_dropcnt", DROP_CNT_O, 64'(m_drops));
`endif
  endtask

  initial begin
    int          stores;
    int          nt;
    int          nv;
    logic [63:0] exp;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] cur;
    logic        b;
    logic [7:0]  t;
    logic        got_req;

    clear_inputs();
    MODE_I   = 1'b0;
    NTRACE_I = '0;
    RST_NI   = 1'b1;
    #3;

    // Capture: one lane, alternating 1,0 starting at bit 0.
    do_reset();
    set_cfg(1'b0, 3'd0);
    stores = 0;
    for (int i = 0; i < 64; i++) begin
      t    = 8'($urandom) & 8'hFE;
      t[0] = (i % 2 == 0);
      sample(t, 1'b1, 1'b1);
      if (i < 63) stores += int'(STORE_O);
    end
    check("cap_early_store", 64'(stores), 64'd0);
    check("cap_store", STORE_O, 1'b1);
    check("cap_data", DATA_O, 64'h5555_5555_5555_5555);
    sample(8'h0, 1'b0, 1'b1);
    check("cap_store_1cyc", STORE_O, 1'b0);

    // Trigger on the 3rd valid cycle with 8 lanes; a later trigger is ignored.
    do_reset();
    set_cfg(1'b0, 3'd3);
    for (int i = 0; i < 10; i++) begin
      TRG_I = (i == 2 || i == 6);
      sample(8'($urandom), 1'b1, 1'b1);
      if (i == 1) check("trg_before", TRG_EVENT_O, 1'b0);
      if (i == 2) begin
        check("trg_event", TRG_EVENT_O, 1'b1);
        check("trg_pos", EVENT_POS_O, 6'd16);
      end
    end
    TRG_I = 1'b0;
    check("trg_event_kept", TRG_EVENT_O, 1'b1);
    check("trg_pos_kept", EVENT_POS_O, 6'd16);

    // Trigger during an invalid cycle stays pending until the next valid sample.
    for (int r = 0; r < 3; r++) begin
      nt = $urandom_range(0, 3);
      nv = $urandom_range(0, 64 / lanes_of(nt) - 1);
      do_reset();
      set_cfg(1'b0, 3'(nt));
      for (int i = 0; i < nv; i++) sample(8'($urandom), 1'b1, 1'b1);
      TRG_I = 1'b1;
      sample(8'($urandom), 1'b0, 1'b1);
      TRG_I = 1'b0;
      sample(8'($urandom), 1'b0, 1'b1);
      check("pend_wait", TRG_EVENT_O, 1'b0);
      sample(8'($urandom), 1'b1, 1'b1);
      check("pend_event", TRG_EVENT_O, 1'b1);
      check("pend_pos", EVENT_POS_O, 64'(nv * lanes_of(nt)));
    end

    // Overflow: word completes without store permission.
    do_reset();
    set_cfg(1'b0, 3'd3);
    for (int i = 0; i < 8; i++) sample(8'($urandom), 1'b1, (i != 7));
    check("ovf_no_store", STORE_O, 1'b0);
    check("ovf_flag", OVERFLOW_O, 1'b1);
`ifdef TRACE_PACKER_STATS_EN
    check("ovf_dropcnt", DROP_CNT_O, 16'd1);
`endif
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      t   = 8'($urandom);
      exp = exp | (64'(t) << (8 * i));
      sample(t, 1'b1, 1'b1);
    end
    check("ovf_next_store", STORE_O, 1'b1);
    check("ovf_next_data", DATA_O, exp);
    check("ovf_sticky", OVERFLOW_O, 1'b1);

    // Freeze after 20 one-lane samples flushes a zero-padded partial word.
    do_reset();
    set_cfg(1'b0, 3'd0);
    exp = '0;
    for (int i = 0; i < 20; i++) begin
      b   = 1'($urandom);
      exp = exp | (64'(b) << i);
      sample({7'($urandom), b}, 1'b1, 1'b1);
    end
    TRG_DELAYED_I = 1'b1;
    sample(8'h0, 1'b0, 1'b1);
    check("frz_store", STORE_O, 1'b1);
    check("frz_data", DATA_O, exp);
    stores = 0;
    for (int i = 0; i < 80; i++) begin
      TRG_DELAYED_I = 1'($urandom);
      sample(8'($urandom), 1'b1, 1'b1);
      stores += int'(STORE_O);
    end
    check("frz_no_more", 64'(stores), 64'd0);
    check("frz_data_kept", DATA_O, exp);

    // Reconfig mid-word: partial word discarded, next word starts at bit 0.
    do_reset();
    set_cfg(1'b0, 3'd0);
    stores = 0;
    for (int i = 0; i < 10; i++) begin
      sample(8'($urandom), 1'b1, 1'b1);
      stores += int'(STORE_O);
    end
    MODE_I   = 1'b0;
    NTRACE_I = 3'd3;
    for (int i = 0; i < 2; i++) begin
      sample(8'h0, 1'b0, 1'b1);
      stores += int'(STORE_O);
    end
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      t   = 8'($urandom);
      exp = exp | (64'(t) << (8 * i));
      sample(t, 1'b1, 1'b1);
      if (i < 7) stores += int'(STORE_O);
    end
    check("rcfg_no_partial", 64'(stores), 64'd0);
    check("rcfg_store", STORE_O, 1'b1);
    check("rcfg_data", DATA_O, exp);

    // Randomised capture against the model, including saturated lane selects.
    random_capture(int'($urandom_range(0, 3)), 400);
    random_capture(int'($urandom_range(4, 7)), 200);

    // Stream: 4 lanes, back-to-back grants on the last slice.
    do_reset();
    set_cfg(1'b1, 3'd2);
    got_req = 1'b0;
    for (int i = 0; i < 8 && !got_req; i++) begin
      if (LOAD_REQUEST_O) got_req = 1'b1;
      else step();
    end
    check("str_req", got_req, 1'b1);
    w0 = 64'h0123_4567_89AB_CDEF;
    w1 = {$urandom, $urandom};
    DATA_I       = w0;
    LOAD_GRANT_I = 1'b1;
    step();
    for (int w = 0; w < 2; w++) begin
      cur = (w == 0) ? w0 : w1;
      for (int s = 0; s < 16; s++) begin
        check("str_valid", STREAM_VALID_O, 1'b1);
        check("str_data", STREAM_O, (cur >> (4 * s)) & 64'hF);
        check("str_req_last", LOAD_REQUEST_O, (s == 15));
        LOAD_GRANT_I = 1'b0;
        DATA_I       = {$urandom, $urandom};
        if (s == 15 && w == 0) begin
          LOAD_GRANT_I = 1'b1;
          DATA_I       = w1;
        end
        if (s == 7 && w == 1) LOAD_GRANT_I = 1'b1;
        step();
      end
    end
    LOAD_GRANT_I = 1'b0;
    check("str_bubble_valid", STREAM_VALID_O, 1'b0);
    check("str_bubble_req", LOAD_REQUEST_O, 1'b1);

    // Asynchronous reset mid-operation.
    #2;
    RST_NI = 1'b0;
    #1;
    check("arst_req", LOAD_REQUEST_O, 1'b0);
    check("arst_svalid", STREAM_VALID_O, 1'b0);
    check("arst_ovf", OVERFLOW_O, 1'b0);
    step();
    RST_NI = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_packer.md
Name: trace_packer

Overview:
- Tracer stage directly upstream of the trace logger.
- Trace mode: packs 1..TRB_MAX_TRACES parallel trace bits per valid cycle into TRB_WIDTH-bit words, hands full words to the logger with a one-cycle store strobe, and reports trigger position within the word.
- Stream mode: requests words from the logger and serialises them onto the trace lanes.

Parameters:
- TRB_WIDTH, 64, memory word width in bits; power of two.
- TRB_MAX_TRACES, 8, maximum parallel trace lanes; power of two, at most TRB_WIDTH.

Ports:
- CLK_I  in  1  clock
- RST_NI  in  1  asynchronous active-low reset
- MODE_I  in  1  0 = trace (capture), 1 = stream (playback)
- NTRACE_I  in  $clog2(TRB_MAX_TRACES)  lane select: lanes = min(2**NTRACE_I, TRB_MAX_TRACES)
- TRACE_I  in  TRB_MAX_TRACES  trace bits; lane k is bit k
- TRACE_VALID_I  in  1  TRACE_I sample valid this cycle
- TRG_I  in  1  raw trigger
- TRG_DELAYED_I  in  1  logger: trigger delay expired, capture frozen
- STORE_PERM_I  in  1  logger accepts a store this cycle
- DATA_O  out  TRB_WIDTH  packed word
- STORE_O  out  1  one-cycle store strobe
- EVENT_POS_O  out  $clog2(TRB_WIDTH)  bit position of the first trigger
- TRG_EVENT_O  out  1  sticky trigger seen
- OVERFLOW_O  out  1  sticky: a full word was dropped
- LOAD_REQUEST_O  out  1  stream mode: word wanted
- LOAD_GRANT_I  in  1  logger: DATA_I valid this cycle
- DATA_I  in  TRB_WIDTH  word from logger
- STREAM_O  out  TRB_MAX_TRACES  playback lanes; unused lanes 0
- STREAM_VALID_O  out  1  STREAM_O valid

Behaviour:
- Reset values:
  - All outputs 0.
  - Fill pointer 0, buffer empty.
  - Registered MODE_I and NTRACE_I both 0.
- Config change:
  - MODE_I and NTRACE_I are registered each cycle.
  - Any difference from the registered copy clears the fill/consume pointer and the buffer-valid flag.
  - Any partial word is discarded without a store.
  - Sticky flags are kept.
- Trace mode, states IDLE, FILL, FROZEN:
  - IDLE to FILL on the first TRACE_VALID_I.
  - FILL: each valid cycle writes TRACE_I[lanes-1:0] at bits [ptr+lanes-1:ptr] of the shadow word; ptr += lanes.
  - When ptr+lanes == TRB_WIDTH, the word is complete:
    - With STORE_PERM_I=1 that same cycle: DATA_O <= word and STORE_O=1 the next cycle (latency 1).
    - With STORE_PERM_I=0: word dropped, OVERFLOW_O<=1.
    - In both cases ptr wraps to 0 and packing continues without gaps.
  - STORE_O is never high two cycles in a row unless lanes == TRB_WIDTH.
  - FILL to FROZEN when TRG_DELAYED_I=1, sampled at the clock edge:
    - A complete word on that same edge is still stored.
    - A partial word is flushed with STORE_O, upper bits 0.
    - FROZEN ignores TRACE_I until reset or a mode change.
- Trigger:
  - First TRG_I=1 while in FILL with TRACE_VALID_I=1 sets TRG_EVENT_O=1 next cycle.
  - Same edge sets EVENT_POS_O = ptr for that cycle.
  - Later triggers are ignored.
  - TRG_I while not valid is held pending until the next valid cycle.
- Stream mode, states EMPTY, WAIT, SHIFT:
  - EMPTY: LOAD_REQUEST_O=1; moves to WAIT.
  - WAIT: LOAD_REQUEST_O stays 1 until LOAD_GRANT_I. Grant latches DATA_I, drops the request, goes to SHIFT.
  - SHIFT: each cycle STREAM_O[lanes-1:0] = buf[ptr+lanes-1:ptr], STREAM_VALID_O=1, ptr += lanes.
  - On the last slice: LOAD_REQUEST_O=1 that same cycle. LOAD_GRANT_I on that cycle refills with no bubble; otherwise go to WAIT with STREAM_VALID_O=0.
  - LOAD_GRANT_I outside WAIT or the last slice is ignored.
- Arithmetic: ptr is $clog2(TRB_WIDTH) bits and wraps modulo TRB_WIDTH; lanes divides TRB_WIDTH by construction.
- Reset mid-operation: all state returns to reset values asynchronously.

Optional Feature:
- Macro: TRACE_PACKER_STATS_EN.
- Defined:
  - Adds output DROP_CNT_O, 16 bits.
  - Counts dropped words, saturating at 0xFFFF; cleared only by reset.
- Undefined: the port and counter do not exist; OVERFLOW_O is unchanged.

Decomposition:
- DTB_PKG holds:
  - TRB_WIDTH and TRB_MAX_TRACES.
  - Enum packer_state_t {IDLE, FILL, FROZEN, EMPTY, WAIT, SHIFT}.
  - Function lanes_from_ntrace().
- Sub-module trace_lane_mux: combinational insert/extract of a lanes-wide slice at ptr. It is shared by the pack and unpack paths.

Test Plan:
- Capture: NTRACE_I=0, TRB_WIDTH=64, 64 valid cycles of TRACE_I[0] alternating 1,0 -> one STORE_O; DATA_O=0x5555_5555_5555_5555.
- Trigger: NTRACE_I=3 (8 lanes), TRG_I on the 3rd valid cycle -> EVENT_POS_O=16 and TRG_EVENT_O=1; a second TRG_I leaves both unchanged.
- Overflow: STORE_PERM_I=0 at word completion -> no STORE_O, OVERFLOW_O=1; DROP_CNT_O=1 with TRACE_PACKER_STATS_EN.
- Freeze: TRG_DELAYED_I after 20 one-lane samples -> STORE_O with DATA_O[19:0] holding the samples and [63:20]=0; no further stores.
- Stream: MODE_I=1, NTRACE_I=2, grant DATA_I=0x0123_4567_89AB_CDEF with an immediate second grant -> STREAM_O = 0xF,0xE,0xD,... for 16 cycles with no bubble.
- Reconfig: change NTRACE_I mid-word -> no store for the partial word; the next word is packed from bit 0.
